data_memory: RTL and testbench
==============================

# data_memory

Data memory stage directly downstream of the ALU in the single-cycle MIPS datapath. It takes the ALU result as a byte address and the second register operand as store data. It performs sized big-endian loads and stores (byte/half/word, signed or unsigned loads) and flags misaligned accesses. An optional post-reset clear sweep zeroes the array and holds the core off with `ready` until the sweep completes.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `ADDR_W`, `$clog2(DEPTH)`: word-index width; derived, never overridden.

Ports:
- `clk`  input  1  clock, rising-edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `address`  input  32  byte address (from ALU result).
- `writeData`  input  32  store data (from register read port 2); low bits used for SB/SH.
- `MemRead`  input  1  load enable.
- `MemWrite`  input  1  store enable.
- `MemSize`  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `MemUnsigned`  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- `readData`  output  32  load result (combinational).
- `ready`  output  1  memory usable; 0 during reset and clear sweep.
- `misaligned`  output  1  current access violates alignment (combinational).
- `errValid`  output  1  sticky: a misaligned access has occurred since reset.
- `badAddr`  output  32  address of the first misaligned access since reset.

## Operation
- Word index = `address[ADDR_W+1:2]`; upper address bits ignored (aliasing wrap-around, no range error).
- Big-endian lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; halfword offset 0 = bits 31:16.
- Alignment: half requires `address[0]==0`, word requires `address[1:0]==0`, byte is always aligned. `misaligned` = (MemRead|MemWrite) & violation.
- Load: selected lane right-justified, then sign- or zero-extended to 32 bits. Word loads ignore `MemUnsigned`.
- Store: only the addressed lane(s) updated; other bytes of the word unchanged. SB writes `writeData[7:0]`, SH writes `writeData[15:0]`.
- A store commits only when `ready & ~misaligned`. A misaligned load returns 0.
- `readData` = 0 whenever `MemRead==0`, `ready==0`, or `misaligned`.
- First misaligned access while `ready` and `errValid==0`: `badAddr` ← `address`, `errValid` ← 1 at the next edge. Later faults leave both unchanged.
- FSM states:
  - CLEAR: writes zero to one word per cycle via `clrIdx` 0 → DEPTH-1. Goes to READY after writing DEPTH-1.
  - READY: normal operation; terminal until reset.
- Reset values: state = CLEAR, `clrIdx`=0, `ready`=0, `errValid`=0, `badAddr`=0. Array contents are not reset directly.
- Reset asserted mid-sweep or mid-operation: state returns to CLEAR with `clrIdx`=0 immediately (asynchronous).
- Core accesses during CLEAR are ignored: no write, `readData`=0, no error capture.

## Timing
- Load latency 0: `readData` valid in the same cycle as `address`/`MemRead`.
- Store visible at the rising edge that ends the access cycle. A load of the same word in the next cycle returns the new value.
- Simultaneous MemRead and MemWrite to the same word: `readData` shows the pre-store contents during that cycle.
- Clear sweep takes exactly DEPTH cycles after `rst_n` deasserts. `ready` rises on edge DEPTH (e.g. 256 for the default).
- `errValid`/`badAddr` update one edge after the faulting access.

## Configuration
- `DMEM_CLEAR_EN` defined: CLEAR state and `clrIdx` counter present; behaviour as above.
- `DMEM_CLEAR_EN` undefined: no sweep. Reset state is READY, and `ready` = 1 one edge after `rst_n` deasserts (registered). Array content after power-up is undefined (X in simulation).

## Structure
- Package `dmem_pkg`: size codes (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), FSM state enum (`ST_CLEAR`, `ST_READY`), and the misalignment-check function.
- Sub-module `dmem_lane_align`: combinational. Produces byte-write enables and lane-shifted store data from `address[1:0]`, `MemSize`, and `writeData`. Also extracts and extends load data from the raw word. Top level holds the array, FSM, and error registers.

## Test plan
- Reset release with `DMEM_CLEAR_EN`, DEPTH=256 → `ready` low for 256 cycles, high at edge 256. LW from 0x000 and 0x3FC returns 0.
- SW 0x11223344 @0x10; SB 0xAA @0x11; LW @0x10 → 0x11AA3344. LBU @0x11 → 0x000000AA. LB @0x11 → 0xFFFFFFAA.
- SH 0x8001 @0x22 over word 0; LH @0x22 → 0xFFFF8001. LHU → 0x00008001. LW @0x20 → 0x00008001.
- SW @0x13 (misaligned) → `misaligned`=1, memory unchanged, `errValid`=1 and `badAddr`=0x13 next edge. A later LH @0x15 leaves `badAddr`=0x13.
- Aliasing: SW 0xDEADBEEF @0x400 (DEPTH=256) → LW @0x000 returns 0xDEADBEEF.
- Assert `rst_n` low at sweep cycle 100 → `ready`=0 immediately. After release, sweep restarts and `ready` rises 256 cycles later. Writes issued during the sweep have no effect.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory stage: size codes, FSM states,
// and the alignment rule.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_CLEAR,
        ST_READY
    } dmem_state_e;

    // Size code 2'b11 is reserved and checked like a word.
    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: store byte enables / replicated store data, and
// load lane extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Byte offset 0 lives in bits 31:24; be_o[3] enables that byte.
    always_comb begin
        lane_b = 8'h00;
        case (addr_off_i)
            2'd0:    lane_b = rword_i[31:24];
            2'd1:    lane_b = rword_i[23:16];
            2'd2:    lane_b = rword_i[15:8];
            default: lane_b = rword_i[7:0];
        endcase
        lane_h = addr_off_i[1] ? rword_i[15:0] : rword_i[31:16];
    end

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = 32'h0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b1000 >> addr_off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                be_o    = addr_off_i[1] ? 4'b0011 : 4'b1100;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Single-cycle MIPS data memory: sized big-endian loads/stores, misalignment
// trap capture. Define DMEM_CLEAR_EN for the post-reset zeroing sweep.
module data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned  DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    output logic [31:0] readData,
    output logic        ready,
    output logic        misaligned,
    output logic        errValid,
    output logic [31:0] badAddr
);

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] clr_idx;
    logic              clr_we;
    logic [3:0]        byte_en;
    logic [31:0]       store_data;
    logic [31:0]       load_data;
    logic              core_we;
    logic              err_valid_q, err_valid_d;
    logic [31:0]       bad_addr_q, bad_addr_d;

`ifdef DMEM_CLEAR_EN
    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_READY;
            end
            ST_READY: ;
        endcase
    end

    assign clr_idx = clr_idx_q;
    assign ready   = (state_q == ST_READY);
`else
    logic ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign clr_idx = '0;
    assign clr_we  = 1'b0;
    assign ready   = ready_q;
`endif

    assign word_idx   = address[ADDR_W+1:2];
    assign misaligned = (MemRead | MemWrite) & is_misaligned(address[1:0], MemSize);
    assign core_we    = MemWrite & ready & ~misaligned;

    dmem_lane_align u_lane_align (
        .addr_off_i (address[1:0]),
        .size_i     (MemSize),
        .unsigned_i (MemUnsigned),
        .wdata_i    (writeData),
        .rword_i    (mem_q[word_idx]),
        .be_o       (byte_en),
        .wdata_o    (store_data),
        .rdata_o    (load_data)
    );

    assign readData = (MemRead & ready & ~misaligned) ? load_data : 32'h0;

    // Array has no reset; the sweep (when built in) owns the write port.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx] <= 32'h0;
        end else if (core_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        err_valid_d = err_valid_q;
        bad_addr_d  = bad_addr_q;
        if (misaligned && ready && !err_valid_q) begin
            err_valid_d = 1'b1;
            bad_addr_d  = address;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            bad_addr_q  <= 32'h0;
        end else begin
            err_valid_q <= err_valid_d;
            bad_addr_q  <= bad_addr_d;
        end
    end

    assign errValid = err_valid_q;
    assign badAddr  = bad_addr_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (DEPTH=256); sweep checks
// adapt to whether DMEM_CLEAR_EN is defined.
module tb_data_memory;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [31:0] readData;
    logic        ready;
    logic        misaligned;
    logic        errValid;
    logic [31:0] badAddr;

    int tests = 0;
    int fails = 0;
    int edges;

`ifdef DMEM_CLEAR_EN
    localparam int ExpReadyEdges = 256;
`else
    localparam int ExpReadyEdges = 1;
`endif

    data_memory #(.DEPTH(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .writeData   (writeData),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemSize     (MemSize),
        .MemUnsigned (MemUnsigned),
        .readData    (readData),
        .ready       (ready),
        .misaligned  (misaligned),
        .errValid    (errValid),
        .badAddr     (badAddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic un);
        address     = a;
        writeData   = wd;
        MemRead     = rd;
        MemWrite    = wr;
        MemSize     = sz;
        MemUnsigned = un;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, SZ_WORD, 1'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        @(negedge clk);
        drive(a, wd, 1'b0, 1'b1, sz, 1'b0);
        @(posedge clk);
        #1 idle();
    endtask

    task automatic load(input string name, input logic [31:0] a, input logic [1:0] sz,
                        input logic un, input logic [31:0] exp);
        @(negedge clk);
        drive(a, 32'h0, 1'b1, 1'b0, sz, un);
        #1 check(name, readData, exp);
    endtask

    task automatic wait_ready(output int n_edges);
        n_edges = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                n_edges = n;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h0, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_errValid", {31'h0, errValid}, 32'h0);
        check("rst_badAddr", badAddr, 32'h0);
        check("rst_readData_gated", readData, 32'h0);
        idle();

        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(edges);
        check("ready_edges", edges, ExpReadyEdges);

`ifdef DMEM_CLEAR_EN
        load("lw_0x000_cleared", 32'h000, SZ_WORD, 1'b0, 32'h0);
        load("lw_0x3fc_cleared", 32'h3FC, SZ_WORD, 1'b0, 32'h0);
`endif

        // Byte merge into a word; upper writeData bits must be ignored by SB.
        store(32'h10, 32'h11223344, SZ_WORD);
        store(32'h11, 32'hFFFFFFAA, SZ_BYTE);
        load("lw_0x10", 32'h10, SZ_WORD, 1'b0, 32'h11AA3344);
        load("lbu_0x11", 32'h11, SZ_BYTE, 1'b1, 32'h000000AA);
        load("lb_0x11", 32'h11, SZ_BYTE, 1'b0, 32'hFFFFFFAA);
        load("lb_0x13", 32'h13, SZ_BYTE, 1'b0, 32'h00000044);
        load("lh_0x10", 32'h10, SZ_HALF, 1'b0, 32'h000011AA);
        load("lhu_0x12", 32'h12, SZ_HALF, 1'b1, 32'h00003344);
        load("lw_unsigned_ignored", 32'h10, SZ_WORD, 1'b1, 32'h11AA3344);

        store(32'h20, 32'h0, SZ_WORD);
        store(32'h22, 32'h12348001, SZ_HALF);
        load("lh_0x22", 32'h22, SZ_HALF, 1'b0, 32'hFFFF8001);
        load("lhu_0x22", 32'h22, SZ_HALF, 1'b1, 32'h00008001);
        load("lw_0x20", 32'h20, SZ_WORD, 1'b0, 32'h00008001);

        // Read and write of the same word: old value visible, new one next cycle.
        @(negedge clk);
        drive(32'h10, 32'h55667788, 1'b1, 1'b1, SZ_WORD, 1'b0);
        #1 check("rw_same_cycle_old", readData, 32'h11AA3344);
        @(posedge clk);
        #1 idle();
        load("lw_after_rw", 32'h10, SZ_WORD, 1'b0, 32'h55667788);

        // Misalignment detection and first-fault capture.
        @(negedge clk);
        drive(32'h13, 32'hCAFEF00D, 1'b0, 1'b0, SZ_WORD, 1'b0);
        #1 check("no_access_not_misaligned", {31'h0, misaligned}, 32'h0);
        check("err_clear_before_fault", {31'h0, errValid}, 32'h0);
        drive(32'h13, 32'hCAFEF00D, 1'b0, 1'b1, SZ_WORD, 1'b0);
        #1 check("sw_0x13_misaligned", {31'h0, misaligned}, 32'h1);
        check("errValid_not_before_edge", {31'h0, errValid}, 32'h0);
        @(posedge clk);
        #1 idle();
        check("errValid_set", {31'h0, errValid}, 32'h1);
        check("badAddr_0x13", badAddr, 32'h13);
        load("mem_unchanged_after_bad_sw", 32'h10, SZ_WORD, 1'b0, 32'h55667788);

        @(negedge clk);
        drive(32'h15, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b0);
        #1 check("lh_0x15_misaligned", {31'h0, misaligned}, 32'h1);
        check("lh_0x15_readData_zero", readData, 32'h0);
        @(posedge clk);
        #1 idle();
        check("badAddr_sticky", badAddr, 32'h13);
        check("errValid_sticky", {31'h0, errValid}, 32'h1);

        @(negedge clk);
        drive(32'h13, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b0);
        #1 check("lb_odd_aligned", {31'h0, misaligned}, 32'h0);
        drive(32'h12, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0);
        #1 check("reserved_size_as_word", {31'h0, misaligned}, 32'h1);
        idle();

        // Upper address bits alias onto the same words.
        store(32'h400, 32'hDEADBEEF, SZ_WORD);
        load("alias_lw_0x000", 32'h000, SZ_WORD, 1'b0, 32'hDEADBEEF);

        // Asynchronous reset in the middle of normal operation.
        @(negedge clk);
        idle();
        #2 rst_n = 1'b0;
        #1 check("async_rst_ready", {31'h0, ready}, 32'h0);
        check("async_rst_errValid", {31'h0, errValid}, 32'h0);
        check("async_rst_badAddr", badAddr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
        // Interrupt the sweep at cycle 100, then watch the restarted sweep.
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("midsweep_rst_ready", {31'h0, ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                edges = n;
                break;
            end
            if (n == 5) drive(32'h000, 32'hBAD0BAD0, 1'b1, 1'b1, SZ_WORD, 1'b0);
            if (n == 6) check("sweep_readData_zero", readData, 32'h0);
            if (n == 10) drive(32'h013, 32'hBAD0BAD0, 1'b0, 1'b1, SZ_WORD, 1'b0);
            if (n == 12) idle();
        end
        idle();
        check("resweep_ready_edges", edges, 256);
        check("sweep_no_err_capture", {31'h0, errValid}, 32'h0);
        load("sweep_write_ignored", 32'h000, SZ_WORD, 1'b0, 32'h0);
`else
        wait_ready(edges);
        check("rerelease_ready_edges", edges, 1);
`endif

        @(negedge clk);
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
